key_click_decoder: RTL

Classifies debounced key activity into single-click, double-click and long-press events for the UI/control logic. Sits directly downstream of the key debouncer. Consumes that block's one-cycle `key_flag` press pulse (issued after 20 ms of stable low) together with the raw active-low `key_in` level, which it uses for release detection. Emits one-cycle event pulses, one per gesture.

---
 rtl/key_click_decoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/key_click_decoder.sv
// Turns debounced key presses into single-click, double-click and long-press pulses.
// Only the synchronized key level drives release detection; key_flag marks each press.
module key_click_decoder #(
  parameter logic [25:0] LONG_CNT = 26'd49_999_999,
  parameter logic [25:0] DBL_WIN  = 26'd14_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  input  logic       key_flag,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t      state;
  logic [25:0] cnt;
  logic        key_meta;
  logic        key_s;

  // Reset to 1 so a key held through reset is not seen as a release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= 26'd0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        IDLE: begin
          if (key_flag) begin
            state <= PRESS1;
            cnt   <= 26'd0;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          // Release wins over long expiry on the same edge.
          if (key_s) begin
            state <= WAIT2;
            cnt   <= 26'd0;
          end else if (cnt == LONG_CNT) begin
            long_press <= 1'b1;
            state      <= LONG_HOLD;
            cnt        <= 26'd0;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        LONG_HOLD: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= 26'd0;
            busy  <= 1'b0;
          end
        end
        WAIT2: begin
          // key_s is ignored here, so release bounce cannot disturb the window.
          if (key_flag) begin
            double_click <= 1'b1;
            state        <= PRESS2;
            cnt          <= 26'd0;
          end else if (cnt == DBL_WIN) begin
            single_click <= 1'b1;
            state        <= IDLE;
            cnt          <= 26'd0;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        PRESS2: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= 26'd0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 26'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
